mem_arbiter: RTL and testbench

- Shares the multicycle CPU's single unified instruction/data memory between two requesters: the CPU control path (port 0) and the debug unit DBU (port 1).
- Serialises whole transactions with a fixed memory latency and returns read data and an acknowledge to the winning requester.
- Drives a stall to the CPU so its control FSM holds its state while the memory is unavailable.

---
 rtl/cod_mem_pkg.sv | 20 ++
 rtl/arb_rr2.sv | 45 ++++
 rtl/mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cod_mem_pkg.sv
// -----------------------------------------------------------------------------
// cod_mem_pkg
// Shared definitions for the unified-memory arbiter: FSM state encoding,
// requester identifiers and the default memory latency.
// -----------------------------------------------------------------------------
package cod_mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_e;

    localparam logic ID_CPU = 1'b0;
    localparam logic ID_DBU = 1'b1;

    localparam int MEM_LAT_DEFAULT = 1;

endpackage

// File: rtl/arb_rr2.sv
// -----------------------------------------------------------------------------
// arb_rr2
// Two-input grant logic for the memory arbiter. Purely combinational.
//
// Build option: MEM_ARB_DBU_PRIO_EN
//   defined   - DBU always wins a tie (last_gnt ignored)
//   undefined - a tie is granted to ~last_gnt (round-robin)
//
// Ports:
//   req[1:0]   in   request vector, bit 0 = CPU, bit 1 = DBU
//   last_gnt   in   id of the previously granted requester
//   gnt_id     out  id of the requester to grant (valid with gnt_valid)
//   gnt_valid  out  at least one request is pending
// -----------------------------------------------------------------------------
module arb_rr2
    import cod_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       gnt_id,
    output logic       gnt_valid
);

`ifdef MEM_ARB_DBU_PRIO_EN
    // Fixed priority does not need the history bit.
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;
`endif

    always_comb begin
        gnt_valid = |req;
        gnt_id    = ID_CPU;
        case (req)
            2'b01:   gnt_id = ID_CPU;
            2'b10:   gnt_id = ID_DBU;
`ifdef MEM_ARB_DBU_PRIO_EN
            2'b11:   gnt_id = ID_DBU;
`else
            2'b11:   gnt_id = ~last_gnt;
`endif
            default: gnt_id = ID_CPU;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one unified instruction/data memory between the CPU control path
// (port 0) and the debug unit (port 1). Whole transactions are serialised:
// IDLE (arbitrate) -> ISSUE (one mem_en cycle) -> WAIT (MEM_LAT cycles)
// -> ACK (one-cycle ack to the winner) -> IDLE.
//
// Build option: MEM_ARB_DBU_PRIO_EN (inside arb_rr2) selects fixed DBU
// priority on ties instead of round-robin.
//
// Handshake (both requester ports): req is a level held, with we/addr/wdata
// stable, until the one-cycle ack; rdata is valid while ack is high. The
// requester must drop req, or present its next transaction, by the clock
// edge that ends the ack cycle; a req seen high in IDLE is a new transaction.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-low reset
//   cpu_req/we/addr/wdata     CPU request side
//   cpu_ack/rdata/stall       CPU completion side, stall = req & ~ack
//   dbu_*                     same as cpu_* for the debug unit (no stall)
//   mem_en/we/addr/wdata      memory strobe and write side (zero outside ISSUE)
//   mem_rdata                 memory read data, valid MEM_LAT cycles after mem_en
//   busy                      state != IDLE
//   dbg_state                 current FSM state
// -----------------------------------------------------------------------------
module mem_arbiter
    import cod_mem_pkg::*;
#(
    parameter int AW      = 8,
    parameter int DW      = 32,
    parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,

    input  logic          dbu_req,
    input  logic          dbu_we,
    input  logic [AW-1:0] dbu_addr,
    input  logic [DW-1:0] dbu_wdata,
    output logic          dbu_ack,
    output logic [DW-1:0] dbu_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy,
    output logic [1:0]    dbg_state
);

    localparam int CW = 3;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

    state_e        state_q, state_d;
    logic          last_gnt_q, last_gnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          gnt_q, gnt_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] dbu_rdata_q, dbu_rdata_d;

    logic          arb_gnt_id;
    logic          arb_gnt_valid;

    arb_rr2 u_arb (
        .req       ({dbu_req, cpu_req}),
        .last_gnt  (last_gnt_q),
        .gnt_id    (arb_gnt_id),
        .gnt_valid (arb_gnt_valid)
    );

    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dbu_rdata_d = dbu_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (arb_gnt_valid) begin
                    // Latch the whole winning transaction so the requester
                    // inputs are not needed after this edge.
                    state_d    = S_ISSUE;
                    gnt_d      = arb_gnt_id;
                    last_gnt_d = arb_gnt_id;
                    if (arb_gnt_id == ID_DBU) begin
                        we_d    = dbu_we;
                        addr_d  = dbu_addr;
                        wdata_d = dbu_wdata;
                    end else begin
                        we_d    = cpu_we;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    // Captured for writes too; the value is simply unused.
                    if (gnt_q == ID_DBU) begin
                        dbu_rdata_d = mem_rdata;
                    end else begin
                        cpu_rdata_d = mem_rdata;
                    end
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            last_gnt_q  <= ID_DBU;   // CPU wins the first tie
            cnt_q       <= '0;
            gnt_q       <= ID_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dbu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbu_rdata_q <= dbu_rdata_d;
        end
    end

    logic in_issue;
    logic in_ack;
    assign in_issue = (state_q == S_ISSUE);
    assign in_ack   = (state_q == S_ACK);

    assign mem_en    = in_issue;
    assign mem_we    = in_issue & we_q;
    assign mem_addr  = in_issue ? addr_q  : '0;
    assign mem_wdata = in_issue ? wdata_q : '0;

    assign cpu_ack   = in_ack & (gnt_q == ID_CPU);
    assign dbu_ack   = in_ack & (gnt_q == ID_DBU);
    assign cpu_rdata = cpu_rdata_q;
    assign dbu_rdata = dbu_rdata_q;

    // Gated by rst so every output reads zero while reset is held, even if
    // the CPU keeps its request asserted.
    assign cpu_stall = rst & cpu_req & ~cpu_ack;

    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import cod_mem_pkg::*;

  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int LAT  = 1;
  localparam int LAT3 = 3;
  localparam int EW   = DW + 2;   // {check_data, id, data}

`ifdef MEM_ARB_DBU_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (MEM_LAT = 1) ----------------
  logic          cpu_req, cpu_we, dbu_req, dbu_we;
  logic [AW-1:0] cpu_addr, dbu_addr;
  logic [DW-1:0] cpu_wdata, dbu_wdata;
  logic          cpu_ack, cpu_stall, dbu_ack;
  logic [DW-1:0] cpu_rdata, dbu_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0]    dbg_state;

  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbu_req(dbu_req), .dbu_we(dbu_we), .dbu_addr(dbu_addr), .dbu_wdata(dbu_wdata),
    .dbu_ack(dbu_ack), .dbu_rdata(dbu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- DUT (MEM_LAT = 3), CPU port only ----------------
  logic          c3_req;
  logic [AW-1:0] c3_addr;
  logic          c3_we = 1'b0;
  logic [DW-1:0] c3_wdata = '0;
  logic          d3_req = 1'b0, d3_we = 1'b0;
  logic [AW-1:0] d3_addr = '0;
  logic [DW-1:0] d3_wdata = '0;
  logic          c3_ack, c3_stall, d3_ack, m3_en, m3_we, busy3;
  logic [DW-1:0] c3_rdata, d3_rdata, m3_wdata, m3_rdata;
  logic [AW-1:0] m3_addr;
  logic [1:0]    dbg_state3;

  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT3)) u_dut3 (
    .clk(clk), .rst(rst),
    .cpu_req(c3_req), .cpu_we(c3_we), .cpu_addr(c3_addr), .cpu_wdata(c3_wdata),
    .cpu_ack(c3_ack), .cpu_rdata(c3_rdata), .cpu_stall(c3_stall),
    .dbu_req(d3_req), .dbu_we(d3_we), .dbu_addr(d3_addr), .dbu_wdata(d3_wdata),
    .dbu_ack(d3_ack), .dbu_rdata(d3_rdata),
    .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr), .mem_wdata(m3_wdata),
    .mem_rdata(m3_rdata), .busy(busy3), .dbg_state(dbg_state3)
  );

  // ---------------- memory models ----------------
  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    if (a == 8'h10) return 32'hDEADBEEF;
    return 32'h1000_0000 | {24'h0, a};
  endfunction

  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] pipe [0:LAT-1];
  bit            mem_init_done = 1'b0;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(AW'(i));
      mem_init_done <= 1'b1;
    end else if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr] : '0;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[LAT-1];

  logic [DW-1:0] pipe3 [0:LAT3-1];
  always @(posedge clk) begin
    pipe3[0] <= m3_en ? init_word(m3_addr) : '0;
    for (int i = 1; i < LAT3; i++) pipe3[i] <= pipe3[i-1];
  end
  assign m3_rdata = pipe3[LAT3-1];

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;
  int we_cycles = 0;
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Advance one cycle and run the scoreboard on the main DUT.
  task automatic tick();
    logic [EW-1:0] e;
    logic          gid;
    logic [DW-1:0] gdat;
    @(negedge clk);
    if (mem_en && mem_we) we_cycles++;
    if (rst) begin
      if (!mem_en) chk("idle_mem_bus_zero", {23'h0, mem_we, mem_addr, mem_wdata}, 64'h0);
      if (cpu_ack || dbu_ack) begin
        chk("single_ack", {63'h0, cpu_ack & dbu_ack}, 64'h0);
        gid  = dbu_ack;
        gdat = dbu_ack ? dbu_rdata : cpu_rdata;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack id=%0d rdata=0x%0h exp=no_ack t=%0t", gid, gdat, $time);
        end else begin
          e = exp_q.pop_front();
          chk("ack_id", {63'h0, gid}, {63'h0, e[DW]});
          if (e[EW-1]) chk("ack_rdata", {32'h0, gdat}, {32'h0, e[DW-1:0]});
        end
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic          creq;
    logic          cwe;
    logic [AW-1:0] caddr;
    logic [DW-1:0] cwd;
    logic          dreq;
    logic          dwe;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dwd;
    logic          first_rr;
    logic          first_pr;
    logic [DW-1:0] c_exp;
    logic [DW-1:0] d_exp;
  } vec_t;

  task automatic run_vec(input vec_t v);
    logic          first;
    logic [EW-1:0] ce, de;
    first = PRIO ? v.first_pr : v.first_rr;
    ce = {~v.cwe, ID_CPU, v.c_exp};
    de = {~v.dwe, ID_DBU, v.d_exp};
    if (v.creq && v.dreq) begin
      if (first == ID_DBU) begin exp_q.push_back(de); exp_q.push_back(ce); end
      else begin exp_q.push_back(ce); exp_q.push_back(de); end
    end else if (v.creq) exp_q.push_back(ce);
    else if (v.dreq) exp_q.push_back(de);
    cpu_req = v.creq; cpu_we = v.cwe; cpu_addr = v.caddr; cpu_wdata = v.cwd;
    dbu_req = v.dreq; dbu_we = v.dwe; dbu_addr = v.daddr; dbu_wdata = v.dwd;
    for (int n = 0; n < 40 && (cpu_req || dbu_req); n++) begin
      tick();
      if (cpu_ack) cpu_req = 1'b0;
      if (dbu_ack) dbu_req = 1'b0;
    end
    chk("round_done", {62'h0, cpu_req, dbu_req}, 64'h0);
    cpu_req = 1'b0; dbu_req = 1'b0;
    tick();
    chk("sb_drained", 64'(exp_q.size()), 64'h0);
  endtask

  vec_t vt [8];
  vec_t rv;
  int   n;
  logic [AW-1:0] ra;

  initial begin
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbu_req = 0; dbu_we = 0; dbu_addr = '0; dbu_wdata = '0;
    c3_req = 0; c3_addr = '0;

    //           creq cwe caddr  cwd            dreq dwe daddr  dwd            rr pr  c_exp          d_exp
    vt[0] = '{1'b1, 1'b0, 8'h04, 32'h0,        1'b1, 1'b1, 8'h20, 32'h12345678, 1'b0, 1'b1, 32'h10000004, 32'h0};
    vt[1] = '{1'b1, 1'b0, 8'h04, 32'h0,        1'b1, 1'b1, 8'h20, 32'h12345678, 1'b0, 1'b1, 32'h10000004, 32'h0};
    vt[2] = '{1'b1, 1'b0, 8'h20, 32'h0,        1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 32'h12345678, 32'h0};
    vt[3] = '{1'b1, 1'b0, 8'h10, 32'h0,        1'b1, 1'b0, 8'h04, 32'h0,        1'b1, 1'b1, 32'hDEADBEEF, 32'h10000004};
    vt[4] = '{1'b1, 1'b1, 8'h40, 32'h11112222, 1'b1, 1'b0, 8'h20, 32'h0,        1'b1, 1'b1, 32'h0,        32'h12345678};
    vt[5] = '{1'b0, 1'b0, 8'h00, 32'h0,        1'b1, 1'b0, 8'h40, 32'h0,        1'b1, 1'b1, 32'h0,        32'h11112222};
    vt[6] = '{1'b1, 1'b0, 8'h40, 32'h0,        1'b1, 1'b1, 8'h50, 32'h55556666, 1'b0, 1'b1, 32'h11112222, 32'h0};
    vt[7] = '{1'b1, 1'b0, 8'h50, 32'h0,        1'b1, 1'b0, 8'h50, 32'h0,        1'b0, 1'b1, 32'h55556666, 32'h55556666};

    // ---- reset state ----
    repeat (3) tick();
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_mem_bus", {22'h0, mem_en, mem_we, mem_addr, mem_wdata}, 64'h0);
    chk("rst_acks", {61'h0, cpu_ack, dbu_ack, cpu_stall}, 64'h0);
    chk("rst_rdata", {cpu_rdata, dbu_rdata}, 64'h0);
    rst = 1'b1;
    tick();

    // ---- CPU read alone, latency ----
    cpu_we = 0; cpu_addr = 8'h10; cpu_req = 1;
    exp_q.push_back({1'b1, ID_CPU, 32'hDEADBEEF});
    tick();
    chk("lat_mem_en_k1", {63'h0, mem_en}, 64'h1);
    chk("lat_mem_addr_k1", {56'h0, mem_addr}, 64'h10);
    chk("lat_mem_we_k1", {63'h0, mem_we}, 64'h0);
    tick();
    chk("lat_mem_en_k2", {63'h0, mem_en}, 64'h0);
    chk("lat_ack_k2", {63'h0, cpu_ack}, 64'h0);
    chk("lat_stall_k2", {63'h0, cpu_stall}, 64'h1);
    tick();
    chk("lat_cpu_ack_k3", {63'h0, cpu_ack}, 64'h1);
    chk("lat_cpu_rdata_k3", {32'h0, cpu_rdata}, 64'hDEADBEEF);
    chk("lat_dbu_ack_k3", {63'h0, dbu_ack}, 64'h0);
    chk("lat_stall_k3", {63'h0, cpu_stall}, 64'h0);
    cpu_req = 0;
    tick();
    chk("lat_idle_after", {63'h0, busy}, 64'h0);
    chk("lat_rdata_hold", {32'h0, cpu_rdata}, 64'hDEADBEEF);

    // ---- reset mid-WAIT ----
    cpu_addr = 8'h04; cpu_req = 1;
    tick();
    tick();
    chk("midrst_in_wait", {62'h0, dbg_state}, 64'(S_WAIT));
    #1 rst = 1'b0;
    #1;
    chk("midrst_busy", {63'h0, busy}, 64'h0);
    chk("midrst_state", {62'h0, dbg_state}, 64'(S_IDLE));
    chk("midrst_outs", {61'h0, cpu_ack, dbu_ack, cpu_stall}, 64'h0);
    chk("midrst_rdata", {cpu_rdata, dbu_rdata}, 64'h0);
    chk("midrst_mem_bus", {22'h0, mem_en, mem_we, mem_addr, mem_wdata}, 64'h0);
    cpu_req = 0;
    tick();
    rst = 1'b1;
    repeat (4) tick();
    chk("midrst_busy_after", {63'h0, busy}, 64'h0);

    // ---- table: arbitration order and data ----
    for (int i = 0; i < 8; i++) run_vec(vt[i]);

    // ---- DBU write then CPU read, single write strobe ----
    we_cycles = 0;
    rv = '{1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 8'h30, 32'hCAFEF00D, 1'b1, 1'b1, 32'h0, 32'h0};
    run_vec(rv);
    rv = '{1'b1, 1'b0, 8'h30, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 32'hCAFEF00D, 32'h0};
    run_vec(rv);
    chk("wr_strobe_count", 64'(we_cycles), 64'h1);

    // ---- random single-port reads of untouched addresses ----
    for (int i = 0; i < 6; i++) begin
      ra = AW'($urandom_range(128, 255));
      if ($urandom_range(0, 1) == 1)
        rv = '{1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, ra, 32'h0, 1'b1, 1'b1, 32'h0, init_word(ra)};
      else
        rv = '{1'b1, 1'b0, ra, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, init_word(ra), 32'h0};
      run_vec(rv);
    end

    // ---- MEM_LAT=3 back-to-back CPU reads ----
    c3_addr = 8'h00; c3_req = 1;
    n = 0;
    do begin
      tick(); n++;
      if (!c3_ack) chk("lat3_stall_a", {63'h0, c3_stall}, 64'h1);
    end while (!c3_ack && n < 20);
    chk("lat3_first_ack_cycles", 64'(n), 64'd5);
    chk("lat3_first_rdata", {32'h0, c3_rdata}, 64'h10000000);
    chk("lat3_stall_at_ack_a", {63'h0, c3_stall}, 64'h0);
    c3_addr = 8'h01;
    n = 0;
    do begin
      tick(); n++;
      if (!c3_ack) chk("lat3_stall_b", {63'h0, c3_stall}, 64'h1);
    end while (!c3_ack && n < 20);
    chk("lat3_second_ack_cycles", 64'(n), 64'd6);
    chk("lat3_second_rdata", {32'h0, c3_rdata}, 64'h10000001);
    chk("lat3_stall_at_ack_b", {63'h0, c3_stall}, 64'h0);
    chk("lat3_no_dbu_ack", {63'h0, d3_ack}, 64'h0);
    c3_req = 0;
    tick();
    chk("lat3_idle_after", {63'h0, busy3}, 64'h0);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
